// File: rtl/flag_branch_unit_pkg.sv
// Shared CPU definitions for the flag/branch unit: condition codes and redirect FSM encoding.
package flag_branch_unit_pkg;

    localparam logic [2:0] COND_NEQ    = 3'b000;
    localparam logic [2:0] COND_EQ     = 3'b001;
    localparam logic [2:0] COND_GT     = 3'b010;
    localparam logic [2:0] COND_LT     = 3'b011;
    localparam logic [2:0] COND_GTE    = 3'b100;
    localparam logic [2:0] COND_LTE    = 3'b101;
    localparam logic [2:0] COND_OVFL   = 3'b110;
    localparam logic [2:0] COND_UNCOND = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } br_state_e;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch condition evaluator; flags are packed {zr, neg, ov}.
module br_cond_eval
    import flag_branch_unit_pkg::*;
(
    input  logic [2:0] flags,
    input  logic [2:0] cond,
    output logic       taken
);

    logic zr;
    logic neg;
    logic ov;

    assign zr  = flags[2];
    assign neg = flags[1];
    assign ov  = flags[0];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_NEQ:    taken = ~zr;
            COND_EQ:     taken = zr;
            COND_GT:     taken = ~zr & ~neg;
            COND_LT:     taken = neg;
            COND_GTE:    taken = ~neg | zr;
            COND_LTE:    taken = neg | zr;
            COND_OVFL:   taken = ov;
            COND_UNCOND: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Committed ALU flags plus a single-entry branch resolver that holds a taken redirect until fetch acks it.
// Handshakes: br_valid/br_ready accept on an edge when both high and not stalled/flushed; redir_valid holds until redir_ack.
module flag_branch_unit
    import flag_branch_unit_pkg::*;
#(
    parameter int PC_W  = 16,
    parameter int OFF_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_zr,
    input  logic             alu_neg,
    input  logic             alu_ov,
    input  logic             upd_all,
    input  logic             upd_z,
    input  logic             stall,
    input  logic             flush,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       br_cond,
    input  logic [OFF_W-1:0] br_off,
    input  logic [PC_W-1:0]  pc_plus1,
    output logic             redir_valid,
    input  logic             redir_ack,
    output logic [PC_W-1:0]  redir_pc,
    output logic             br_resolved,
    output logic             br_taken,
    output logic [2:0]       flags_q
);

    br_state_e       state;
    logic [2:0]      flags_next;
    logic            accept;
    logic            cond_taken;
    logic [PC_W-1:0] off_ext;
    logic [PC_W-1:0] target;

    // The value flags_q will take at this edge; also the bypass source for evaluation.
    always_comb begin
        flags_next = flags_q;
        if (!stall) begin
            if (upd_all) begin
                flags_next = {alu_zr, alu_neg, alu_ov};
            end else if (upd_z) begin
                flags_next = {alu_zr, flags_q[1:0]};
            end
        end
    end

    assign br_ready    = (state == ST_IDLE);
    assign redir_valid = (state == ST_PEND);
    assign accept      = br_valid & br_ready & ~stall & ~flush;
    assign off_ext     = {{(PC_W-OFF_W){br_off[OFF_W-1]}}, br_off};
    assign target      = pc_plus1 + off_ext;

    br_cond_eval u_cond_eval (
        .flags (flags_next),
        .cond  (br_cond),
        .taken (cond_taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            flags_q     <= 3'b000;
            redir_pc    <= '0;
            br_resolved <= 1'b0;
            br_taken    <= 1'b0;
        end else begin
            flags_q     <= flags_next;
            br_resolved <= accept;
            if (accept) begin
                br_taken <= cond_taken;
            end
            case (state)
                ST_IDLE: begin
                    if (accept && cond_taken) begin
                        state    <= ST_PEND;
                        redir_pc <= target;
                    end
                end
                ST_PEND: begin
                    // Flush and ack both retire the redirect; stall has no say here.
                    if (flush || redir_ack) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed-vector bench for flag_branch_unit: flag loads, condition table, redirect handshake, flush/stall, reset.
module tb_flag_branch_unit;

    localparam int PC_W  = 16;
    localparam int OFF_W = 9;

    logic             clk;
    logic             rst_n;
    logic             alu_zr;
    logic             alu_neg;
    logic             alu_ov;
    logic             upd_all;
    logic             upd_z;
    logic             stall;
    logic             flush;
    logic             br_valid;
    logic             br_ready;
    logic [2:0]       br_cond;
    logic [OFF_W-1:0] br_off;
    logic [PC_W-1:0]  pc_plus1;
    logic             redir_valid;
    logic             redir_ack;
    logic [PC_W-1:0]  redir_pc;
    logic             br_resolved;
    logic             br_taken;
    logic [2:0]       flags_q;

    int vectors;
    int miscompares;

    flag_branch_unit #(.PC_W(PC_W), .OFF_W(OFF_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_zr      (alu_zr),
        .alu_neg     (alu_neg),
        .alu_ov      (alu_ov),
        .upd_all     (upd_all),
        .upd_z       (upd_z),
        .stall       (stall),
        .flush       (flush),
        .br_valid    (br_valid),
        .br_ready    (br_ready),
        .br_cond     (br_cond),
        .br_off      (br_off),
        .pc_plus1    (pc_plus1),
        .redir_valid (redir_valid),
        .redir_ack   (redir_ack),
        .redir_pc    (redir_pc),
        .br_resolved (br_resolved),
        .br_taken    (br_taken),
        .flags_q     (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it; inputs are changed only here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        alu_zr = 0; alu_neg = 0; alu_ov = 0; upd_all = 0; upd_z = 0;
        stall = 0; flush = 0; br_valid = 0; br_cond = 3'b000;
        br_off = '0; pc_plus1 = '0; redir_ack = 0;
    endtask

    task automatic load_flags(input logic [2:0] f);
        upd_all = 1; {alu_zr, alu_neg, alu_ov} = f;
        tick();
        upd_all = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        #12;
        vectors++; if (flags_q !== 3'b000) begin miscompares++; $display("FAIL reset_flags got=%b exp=000", flags_q); end
        vectors++; if (redir_valid !== 1'b0) begin miscompares++; $display("FAIL reset_redir_valid got=%b exp=0", redir_valid); end
        vectors++; if (redir_pc !== 16'h0000) begin miscompares++; $display("FAIL reset_redir_pc got=%h exp=0000", redir_pc); end
        vectors++; if (br_resolved !== 1'b0) begin miscompares++; $display("FAIL reset_br_resolved got=%b exp=0", br_resolved); end
        vectors++; if (br_taken !== 1'b0) begin miscompares++; $display("FAIL reset_br_taken got=%b exp=0", br_taken); end
        vectors++; if (br_ready !== 1'b1) begin miscompares++; $display("FAIL reset_br_ready got=%b exp=1", br_ready); end
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic test_flags();
        load_flags(3'b011);
        vectors++; if (flags_q !== 3'b011) begin miscompares++; $display("FAIL flags_upd_all got=%b exp=011", flags_q); end
        upd_z = 1; alu_zr = 1; alu_neg = 0; alu_ov = 0;
        tick();
        upd_z = 0;
        vectors++; if (flags_q !== 3'b111) begin miscompares++; $display("FAIL flags_upd_z got=%b exp=111", flags_q); end
        stall = 1; upd_all = 1; {alu_zr, alu_neg, alu_ov} = 3'b000;
        tick();
        stall = 0; upd_all = 0;
        vectors++; if (flags_q !== 3'b111) begin miscompares++; $display("FAIL flags_stall_hold got=%b exp=111", flags_q); end
        upd_all = 1; upd_z = 1; {alu_zr, alu_neg, alu_ov} = 3'b001;
        tick();
        upd_all = 0; upd_z = 0;
        vectors++; if (flags_q !== 3'b001) begin miscompares++; $display("FAIL flags_all_wins got=%b exp=001", flags_q); end
    endtask

    task automatic test_taken_branch();
        load_flags(3'b100);
        br_valid = 1; br_cond = 3'b001; pc_plus1 = 16'h0010; br_off = 9'h1F0;
        tick();
        br_valid = 0;
        vectors++; if (br_resolved !== 1'b1) begin miscompares++; $display("FAIL eq_resolved got=%b exp=1", br_resolved); end
        vectors++; if (br_taken !== 1'b1) begin miscompares++; $display("FAIL eq_taken got=%b exp=1", br_taken); end
        vectors++; if (redir_valid !== 1'b1) begin miscompares++; $display("FAIL eq_redir_valid got=%b exp=1", redir_valid); end
        vectors++; if (redir_pc !== 16'h0000) begin miscompares++; $display("FAIL eq_redir_pc got=%h exp=0000", redir_pc); end
        vectors++; if (br_ready !== 1'b0) begin miscompares++; $display("FAIL eq_ready got=%b exp=0", br_ready); end
        pc_plus1 = 16'h1234; br_off = 9'h055;
        tick();
        vectors++; if (br_resolved !== 1'b0) begin miscompares++; $display("FAIL pend_resolved_pulse got=%b exp=0", br_resolved); end
        vectors++; if (redir_valid !== 1'b1 || redir_pc !== 16'h0000) begin miscompares++; $display("FAIL pend_hold got=%b/%h exp=1/0000", redir_valid, redir_pc); end
        vectors++; if (br_taken !== 1'b1) begin miscompares++; $display("FAIL pend_taken_hold got=%b exp=1", br_taken); end
        redir_ack = 1; stall = 1;
        tick();
        redir_ack = 0; stall = 0;
        vectors++; if (redir_valid !== 1'b0 || br_ready !== 1'b1) begin miscompares++; $display("FAIL ack_under_stall got=%b/%b exp=0/1", redir_valid, br_ready); end
    endtask

    task automatic test_wrap();
        br_valid = 1; br_cond = 3'b111; pc_plus1 = 16'hFFFF; br_off = 9'h002;
        tick();
        br_valid = 0;
        vectors++; if (redir_pc !== 16'h0001) begin miscompares++; $display("FAIL wrap_up got=%h exp=0001", redir_pc); end
        redir_ack = 1; tick(); redir_ack = 0;
        br_valid = 1; br_cond = 3'b111; pc_plus1 = 16'h0000; br_off = 9'h100;
        tick();
        br_valid = 0;
        vectors++; if (redir_pc !== 16'hFF00) begin miscompares++; $display("FAIL wrap_down got=%h exp=ff00", redir_pc); end
        redir_ack = 1; tick(); redir_ack = 0;
    endtask

    task automatic test_bypass();
        load_flags(3'b000);
        upd_all = 1; {alu_zr, alu_neg, alu_ov} = 3'b100;
        br_valid = 1; br_cond = 3'b000; pc_plus1 = 16'h0200; br_off = 9'h010;
        tick();
        upd_all = 0; br_valid = 0;
        vectors++; if (br_resolved !== 1'b1 || br_taken !== 1'b0) begin miscompares++; $display("FAIL bypass_eval got=%b/%b exp=1/0", br_resolved, br_taken); end
        vectors++; if (redir_valid !== 1'b0) begin miscompares++; $display("FAIL bypass_redir got=%b exp=0", redir_valid); end
        vectors++; if (flags_q !== 3'b100) begin miscompares++; $display("FAIL bypass_flags got=%b exp=100", flags_q); end
        redir_ack = 1; tick(); redir_ack = 0;
        vectors++; if (br_ready !== 1'b1 || redir_valid !== 1'b0) begin miscompares++; $display("FAIL idle_ack_ignored got=%b/%b exp=1/0", br_ready, redir_valid); end
    endtask

    task automatic test_conds();
        logic [2:0] fset [2];
        logic [7:0] etab [2];
        logic       e;
        fset[0] = 3'b010; etab[0] = 8'b10101001;
        fset[1] = 3'b101; etab[1] = 8'b11110010;
        for (int s = 0; s < 2; s++) begin
            load_flags(fset[s]);
            for (int c = 0; c < 8; c++) begin
                br_valid = 1; br_cond = 3'(c); pc_plus1 = 16'h0100; br_off = 9'h004;
                tick();
                br_valid = 0;
                e = etab[s][c];
                vectors++;
                if (br_resolved !== 1'b1 || br_taken !== e || redir_valid !== e) begin
                    miscompares++;
                    $display("FAIL cond f=%b c=%0d got res/tk/rv=%b/%b/%b exp=1/%b/%b", fset[s], c, br_resolved, br_taken, redir_valid, e, e);
                end
                if (e) begin
                    vectors++; if (redir_pc !== 16'h0104) begin miscompares++; $display("FAIL cond_target c=%0d got=%h exp=0104", c, redir_pc); end
                    redir_ack = 1; tick(); redir_ack = 0;
                end
            end
        end
    endtask

    task automatic test_flush_stall();
        br_valid = 1; br_cond = 3'b111; pc_plus1 = 16'h0040; br_off = 9'h001;
        tick();
        br_valid = 0;
        flush = 1; redir_ack = 1;
        tick();
        flush = 0; redir_ack = 0;
        vectors++; if (redir_valid !== 1'b0 || br_ready !== 1'b1) begin miscompares++; $display("FAIL flush_pend got=%b/%b exp=0/1", redir_valid, br_ready); end
        br_valid = 1; flush = 1;
        tick();
        flush = 0; br_valid = 0;
        vectors++; if (br_resolved !== 1'b0 || redir_valid !== 1'b0) begin miscompares++; $display("FAIL flush_blocks_accept got=%b/%b exp=0/0", br_resolved, redir_valid); end
        br_valid = 1; br_cond = 3'b111; stall = 1;
        tick();
        vectors++; if (br_resolved !== 1'b0) begin miscompares++; $display("FAIL stall_hold1 got=%b exp=0", br_resolved); end
        tick();
        vectors++; if (br_resolved !== 1'b0) begin miscompares++; $display("FAIL stall_hold2 got=%b exp=0", br_resolved); end
        stall = 0;
        tick();
        br_valid = 0;
        vectors++; if (br_resolved !== 1'b1 || redir_valid !== 1'b1 || redir_pc !== 16'h0041) begin miscompares++; $display("FAIL stall_release got=%b/%b/%h exp=1/1/0041", br_resolved, redir_valid, redir_pc); end
    endtask

    task automatic test_async_reset();
        #3;
        rst_n = 0;
        #1;
        vectors++; if (redir_valid !== 1'b0 || br_ready !== 1'b1) begin miscompares++; $display("FAIL async_rst_redir got=%b/%b exp=0/1", redir_valid, br_ready); end
        vectors++; if (flags_q !== 3'b000 || redir_pc !== 16'h0000 || br_taken !== 1'b0 || br_resolved !== 1'b0) begin
            miscompares++; $display("FAIL async_rst_regs got=%b/%h/%b/%b exp=000/0000/0/0", flags_q, redir_pc, br_taken, br_resolved);
        end
        @(negedge clk);
        rst_n = 1;
        tick();
        vectors++; if (redir_valid !== 1'b0 || br_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_idle got=%b/%b exp=0/1", redir_valid, br_ready); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_flags();
        test_taken_branch();
        test_wrap();
        test_bypass();
        test_conds();
        test_flush_stall();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
